jtag_shift_master: RTL and testbench

FPGA-side JTAG host that drives the XiangShan debug TAP pins (TCK/TMS/TDI, sampling TDO) from a simple command/response interface. It lets on-board logic, such as a VIO- or UART-fed debug bridge, run TAP reset, IR scans, DR scans and idle cycles without an external probe. It sits beside the core wrapper and feeds the core's system JTAG inputs in place of the GPIO header pins.

---
 rtl/jtag_shift_master.sv | 187 ++++++++++++++++++
 tb/tb_jtag_shift_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_shift_master.sv
// JTAG host: turns reset / IR scan / DR scan / idle commands into TCK/TMS/TDI
// waveforms and returns the TDO bits captured during the shift periods.
module jtag_shift_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [6:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               jtag_tck,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  input  logic               jtag_tdo
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [6:0]    LEN_MAX  = 7'(MAX_LEN);

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  localparam logic [1:0] T_RST = 2'd0, T_IR = 2'd1, T_DR = 2'd2, T_IDLE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [1:0]         type_q, type_d;
  logic [6:0]         len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [6:0]         last_q, last_d;
  logic [6:0]         per_q, per_d;
  logic [DW-1:0]      div_q, div_d;
  logic               phase_q, phase_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;

  logic [6:0] len_clamp;
  logic [6:0] pre_len;
  logic [6:0] shift_k;
  logic       shift_now;

  // TMS/TDI for period p of a command, straight from the TAP path it walks.
  function automatic logic [1:0] drive(input logic [1:0] typ, input logic [6:0] len,
                                       input logic [MAX_LEN-1:0] data, input logic [6:0] p);
    logic [6:0] pre;
    logic [6:0] k;
    logic       tms;
    logic       tdi;
    tms = 1'b0;
    tdi = 1'b0;
    pre = (typ == T_IR) ? 7'd4 : 7'd3;
    k   = p - pre;
    case (typ)
      T_RST:  tms = (p < 7'd5);
      T_IDLE: tms = 1'b0;
      default: begin
        if (p < pre) begin
          tms = (typ == T_IR) ? (p < 7'd2) : (p == 7'd0);
        end else if (k < len) begin
          tms = (k == len - 7'd1);
          tdi = |(data & (MAX_LEN'(1) << k));
        end else begin
          tms = (k == len);
        end
      end
    endcase
    return {tms, tdi};
  endfunction

  assign len_clamp = (cmd_len == 7'd0) ? 7'd1 : ((cmd_len > LEN_MAX) ? LEN_MAX : cmd_len);
  assign pre_len   = (type_q == T_IR) ? 7'd4 : 7'd3;
  assign shift_k   = per_q - pre_len;
  assign shift_now = ((type_q == T_IR) || (type_q == T_DR)) &&
                     (per_q >= pre_len) && (shift_k < len_q);

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    len_d       = len_q;
    data_d      = data_q;
    last_d      = last_q;
    per_d       = per_q;
    div_d       = div_q;
    phase_d     = phase_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          type_d     = cmd_type;
          len_d      = len_clamp;
          data_d     = cmd_data;
          per_d      = 7'd0;
          div_d      = '0;
          phase_d    = 1'b0;
          rsp_data_d = '0;
          // last_d holds N-1, the index of the final TCK period
          case (cmd_type)
            T_RST:   last_d = 7'd5;
            T_IR:    last_d = len_clamp + 7'd5;
            T_DR:    last_d = len_clamp + 7'd4;
            default: last_d = len_clamp - 7'd1;
          endcase
          {tms_d, tdi_d} = drive(cmd_type, len_clamp, cmd_data, 7'd0);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        if (div_q == DIV_LAST) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            // rising TCK edge: TDO is captured on this same clk edge
            tck_d = 1'b1;
            if (shift_now) rsp_data_d = rsp_data_q | (MAX_LEN'(jtag_tdo) << shift_k);
          end else begin
            tck_d = 1'b0;
            if (per_q == last_q) begin
              state_d     = S_DONE;
              rsp_valid_d = 1'b1;
            end else begin
              per_d          = per_q + 7'd1;
              {tms_d, tdi_d} = drive(type_q, len_q, data_q, per_q + 7'd1);
            end
          end
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      type_q      <= T_RST;
      len_q       <= 7'd1;
      data_q      <= '0;
      last_q      <= 7'd0;
      per_q       <= 7'd0;
      div_q       <= '0;
      phase_q     <= 1'b0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      len_q       <= len_d;
      data_q      <= data_d;
      last_q      <= last_d;
      per_q       <= per_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign jtag_tck  = tck_q;
  assign jtag_tms  = tms_q;
  assign jtag_tdi  = tdi_q;

endmodule

// File: tb/tb_jtag_shift_master.sv
// Bench for jtag_shift_master: a behavioural TAP model on the pins plus
// expected TMS/TDI streams, latencies and responses derived from command rules.
module tb_jtag_shift_master;
  localparam int CD = 2;
  localparam int ML = 64;

  localparam int TLR = 0, RTI = 1, SDS = 2, CDR = 3, SDR = 4, E1D = 5, PD = 6, E2D = 7,
                 UDR = 8, SIS = 9, CIR = 10, SIR = 11, E1I = 12, PI = 13, E2I = 14, UIR = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_type = 2'd0;
  logic [6:0]    cmd_len = 7'd0;
  logic [ML-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [ML-1:0] rsp_data;
  logic          jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;

  int n_chk = 0;
  int n_fail = 0;

  int          st = TLR;
  logic [63:0] dr_sr = '0, dr_reg = '0, dr_cap = '0;
  logic [63:0] ir_sr = '0, ir_reg = '0, ir_cap = '0;
  int          dr_len = 8, ir_len = 5;
  logic [1:0]  obs_q[$];

  jtag_shift_master #(.CLK_DIV(CD), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] msk(input int l);
    return (l >= 64) ? {64{1'b1}} : ((64'd1 << l) - 64'd1);
  endfunction

  function automatic int clamp_len(input int len);
    if (len == 0) return 1;
    if (len > ML) return ML;
    return len;
  endfunction

  function automatic int nper(input int typ, input int l);
    case (typ)
      0: return 6;
      1: return l + 6;
      2: return l + 5;
      default: return l;
    endcase
  endfunction

  // Standard 16-state TAP with length-configurable DR/IR shift registers.
  assign jtag_tdo = (st == SDR) ? dr_sr[0] : ((st == SIR) ? ir_sr[0] : 1'b0);

  always @(posedge jtag_tck) begin
    obs_q.push_back({jtag_tms, jtag_tdi});
    case (st)
      TLR: st <= jtag_tms ? TLR : RTI;
      RTI: st <= jtag_tms ? SDS : RTI;
      SDS: st <= jtag_tms ? SIS : CDR;
      CDR: begin dr_sr <= dr_cap & msk(dr_len); st <= jtag_tms ? E1D : SDR; end
      SDR: begin
        dr_sr <= (dr_sr >> 1) | (64'(jtag_tdi) << (dr_len - 1));
        st    <= jtag_tms ? E1D : SDR;
      end
      E1D: st <= jtag_tms ? UDR : PD;
      PD:  st <= jtag_tms ? E2D : PD;
      E2D: st <= jtag_tms ? UDR : SDR;
      UDR: begin dr_reg <= dr_sr; st <= jtag_tms ? SDS : RTI; end
      SIS: st <= jtag_tms ? TLR : CIR;
      CIR: begin ir_sr <= ir_cap & msk(ir_len); st <= jtag_tms ? E1I : SIR; end
      SIR: begin
        ir_sr <= (ir_sr >> 1) | (64'(jtag_tdi) << (ir_len - 1));
        st    <= jtag_tms ? E1I : SIR;
      end
      E1I: st <= jtag_tms ? UIR : PI;
      PI:  st <= jtag_tms ? E2I : PI;
      E2I: st <= jtag_tms ? UIR : SIR;
      UIR: begin ir_reg <= ir_sr; st <= jtag_tms ? SDS : RTI; end
      default: st <= TLR;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int typ, input int len, input logic [63:0] data, input string tag);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    chk({tag, " cmd_ready before accept"}, 64'(cmd_ready), 64'd1);
    obs_q.delete();
    cmd_valid = 1'b1;
    cmd_type  = 2'(typ);
    cmd_len   = 7'(len);
    cmd_data  = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_type  = 2'($urandom);
    cmd_len   = 7'($urandom);
    cmd_data  = {$urandom, $urandom};
  endtask

  // Called #1 after the accepting edge; waits for the response and checks it.
  task automatic finish(input int typ, input int len, input logic [63:0] data,
                        input logic [63:0] exp_rsp, input string tag, input bit handshake);
    int l, n, cyc, bad;
    logic [1:0] exp_q[$];
    l = clamp_len(len);
    n = nper(typ, l);
    case (typ)
      0: begin
        for (int i = 0; i < 5; i++) exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
      end
      1, 2: begin
        if (typ == 1) exp_q = '{2'b10, 2'b10, 2'b00, 2'b00};
        else exp_q = '{2'b10, 2'b00, 2'b00};
        for (int k = 0; k < l; k++) exp_q.push_back({k == l - 1, data[k]});
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
      end
      default: for (int i = 0; i < l; i++) exp_q.push_back(2'b00);
    endcase
    chk({tag, " cmd_ready in run"}, 64'(cmd_ready), 64'd0);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 4000) begin @(posedge clk); #1; cyc++; end
    chk({tag, " latency"}, 64'(cyc), 64'(2 * CD * n));
    chk({tag, " rsp_data"}, rsp_data, exp_rsp);
    chk({tag, " tck periods"}, 64'(obs_q.size()), 64'(n));
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    chk({tag, " tms/tdi mismatching periods"}, 64'(bad), 64'd0);
    chk({tag, " tck idle low"}, 64'(jtag_tck), 64'd0);
    chk({tag, " tap in rti"}, 64'(st), 64'(RTI));
    if (handshake) begin
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({tag, " rsp_valid after handshake"}, 64'(rsp_valid), 64'd0);
      chk({tag, " cmd_ready after handshake"}, 64'(cmd_ready), 64'd1);
    end
  endtask

  task automatic run_cmd(input int typ, input int len, input logic [63:0] data,
                         input logic [63:0] exp_rsp, input string tag);
    issue(typ, len, data, tag);
    finish(typ, len, data, exp_rsp, tag, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int typ, len, l, hits;
    logic [63:0] data, cap, exp;

    // reset held three cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset tck", 64'(jtag_tck), 64'd0);
      chk("reset tms", 64'(jtag_tms), 64'd1);
      chk("reset tdi", 64'(jtag_tdi), 64'd0);
      chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset cmd_ready", 64'(cmd_ready), 64'd0);
    end
    chk("reset rsp_data", rsp_data, 64'd0);
    rst = 1'b0;
    #1;
    chk("cmd_ready after release", 64'(cmd_ready), 64'd1);

    run_cmd(0, 0, {$urandom, $urandom}, 64'd0, "tap reset");

    dr_len = 8; dr_cap = 64'h3C;
    run_cmd(2, 8, 64'hA5, 64'h3C, "dr8");
    chk("dr8 model dr", dr_reg, 64'hA5);

    ir_len = 5; ir_cap = 64'h01;
    run_cmd(1, 5, 64'h11, 64'h01, "ir5");
    chk("ir5 model ir", ir_reg, 64'h11);

    dr_len = 64; dr_cap = 64'hFFFF_0000_1234_5678;
    run_cmd(2, 64, 64'hFFFF_0000_1234_5678, 64'hFFFF_0000_1234_5678, "dr64 loopback");
    chk("dr64 model dr", dr_reg, 64'hFFFF_0000_1234_5678);

    run_cmd(3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "idle len0");

    dr_len = 64; dr_cap = {$urandom, $urandom}; data = {$urandom, $urandom};
    run_cmd(2, 100, data, dr_cap, "dr len100 clamp");
    chk("dr len100 model dr", dr_reg, data);

    for (int r = 0; r < 10; r++) begin
      typ  = int'($urandom_range(0, 3));
      len  = int'($urandom_range(0, 127));
      data = {$urandom, $urandom};
      cap  = {$urandom, $urandom};
      l    = clamp_len(len);
      dr_len = l; dr_cap = cap;
      ir_len = l; ir_cap = cap;
      exp  = (typ == 1 || typ == 2) ? (cap & msk(l)) : 64'd0;
      run_cmd(typ, len, data, exp, $sformatf("rand%0d type%0d len%0d", r, typ, len));
      if (typ == 2) chk($sformatf("rand%0d model dr", r), dr_reg, data & msk(l));
      if (typ == 1) chk($sformatf("rand%0d model ir", r), ir_reg, data & msk(l));
    end

    // response backpressure with the next command already offered
    dr_len = 16; dr_cap = {$urandom, $urandom}; data = {$urandom, $urandom};
    issue(2, 16, data, "bp dr16");
    finish(2, 16, data, dr_cap & msk(16), "bp dr16", 1'b0);
    cmd_valid = 1'b1; cmd_type = 2'd3; cmd_len = 7'd3; cmd_data = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp rsp_valid held", 64'(rsp_valid), 64'd1);
      chk("bp rsp_data held", rsp_data, dr_cap & msk(16));
      chk("bp cmd_ready low", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp cmd_ready after handshake", 64'(cmd_ready), 64'd1);
    chk("bp rsp_valid after handshake", 64'(rsp_valid), 64'd0);
    obs_q.delete();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    finish(3, 3, 64'd0, 64'd0, "bp queued idle3", 1'b1);

    // abort in the middle of a DR scan
    dr_len = 32; dr_cap = {$urandom, $urandom};
    issue(2, 32, {$urandom, $urandom}, "abort dr32");
    repeat (41) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("abort tck", 64'(jtag_tck), 64'd0);
    chk("abort tms", 64'(jtag_tms), 64'd1);
    chk("abort tdi", 64'(jtag_tdi), 64'd0);
    chk("abort rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort rsp_data", rsp_data, 64'd0);
    chk("abort cmd_ready in rst", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || jtag_tck !== 1'b0) hits++;
    end
    chk("abort no response or tck", 64'(hits), 64'd0);
    chk("abort cmd_ready idle", 64'(cmd_ready), 64'd1);
    run_cmd(0, 7, {$urandom, $urandom}, 64'd0, "tap reset after abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
